// File: rtl/reg_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
// The DATA_WIDTH constant must track the CPU register file.
package reg_dump_reader_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    // True when idx addresses the final register of the walk
    function automatic logic is_last_idx(input logic [ADDR_WIDTH-1:0] idx);
        return idx == ADDR_WIDTH'(NUM_REGS - 1);
    endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready beat stream carrying (address, data, last) toward the debug path.
interface reg_dump_reader_if;
    import reg_dump_reader_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_reader_out_stage.sv
// Single-entry valid/ready output register; reusable by other debug streamers.
module reg_dump_out_stage
    import reg_dump_reader_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  beat_t beat,
    output logic  load_c,
    reg_dump_reader_if.master bus
);

    assign load_c = !bus.out_valid || bus.out_ready;

    // A push lands only when the slot is free or being drained this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else if (push && load_c) begin
            bus.out_valid <= 1'b1;
            bus.out_addr  <= beat.addr;
            bus.out_data  <= beat.data;
            bus.out_last  <= beat.last;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file read port and streams (addr, data) beats out.
// Optional REG_DUMP_CHECKSUM_EN adds an XOR checksum of accepted beats.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
`ifdef REG_DUMP_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    reg_dump_reader_if.master     out
);

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_n;
    logic                  push_c;
    logic                  load_c;
    logic                  accept_c;
    beat_t                 beat_c;

    assign rd_addr  = ptr;
    assign accept_c = out.out_valid && out.out_ready;
    assign beat_c   = '{addr: ptr, data: rd_data, last: is_last_idx(ptr)};

    reg_dump_out_stage u_out_stage (
        .clk    (clk),
        .reset  (reset),
        .push   (push_c),
        .beat   (beat_c),
        .load_c (load_c),
        .bus    (out)
    );

    // Next-state and pointer; ptr parks on the last index once it is loaded
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        push_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                ptr_n = '0;
                if (start) begin
                    push_c  = 1'b1;
                    state_n = ST_STREAM;
                end
            end
            ST_STREAM: begin
                push_c = load_c && !out.out_last;
                if (accept_c && out.out_last) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_n   = '0;
                state_n = ST_IDLE;
            end
            default: begin
                ptr_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
        if (push_c && !is_last_idx(ptr)) begin
            ptr_n = ptr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            busy  <= (state_n != ST_IDLE);
            done  <= (state_n == ST_DONE);
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // Cleared on an accepted start, so it stays final from done until the next dump
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum ^ out.out_data;
        end
    end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader against a register-array reference model.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    int vectors     = 0;
    int miscompares = 0;

    reg_dump_reader_if bus ();

    reg_dump_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
`ifdef REG_DUMP_CHECKSUM_EN
        .checksum (checksum),
`endif
        .out      (bus)
    );

    always #5 clk = ~clk;

    // Combinational register file read port
    assign rd_data = regs[rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_addr"},  64'(bus.out_addr),  64'd0);
        check({tag, "_data"},  64'(bus.out_data),  64'd0);
        check({tag, "_last"},  64'(bus.out_last),  64'd0);
        check({tag, "_busy"},  64'(busy),          64'd0);
        check({tag, "_done"},  64'(done),          64'd0);
        check({tag, "_rdaddr"}, 64'(rd_addr),      64'd0);
`ifdef REG_DUMP_CHECKSUM_EN
        check({tag, "_csum"},  64'(checksum),      64'd0);
`endif
    endtask

    // One dump from IDLE; entered and left at posedge+1. Indices of -1 disable a feature.
    task automatic run_dump(input int stall_pct, input int stall_idx, input int busy_start_idx,
                            input int rst_idx, input int wr_idx,
                            input logic [DATA_WIDTH-1:0] wr_val, input int exp_cycles);
        int                    nxt = 0;
        int                    cyc = 0;
        int                    stall_left = 3;
        logic [DATA_WIDTH-1:0] cs = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        while (nxt < int'(NUM_REGS) && cyc < 500) begin
            if (nxt == rst_idx) begin
                reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                @(posedge clk); #1;
                reset = 1'b0;
                bus.out_ready = 1'b1;
                return;
            end
            start = (nxt == busy_start_idx);
            if (wr_idx >= 0 && nxt == wr_idx - 5) regs[wr_idx] = wr_val;
            if (nxt == stall_idx && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(99) >= stall_pct);
            end
            @(negedge clk);
            check("valid", 64'(bus.out_valid), 64'd1);
            check("addr",  64'(bus.out_addr),  64'(nxt));
            check("data",  64'(bus.out_data),  64'(regs[nxt]));
            check("last",  64'(bus.out_last),  64'(nxt == int'(NUM_REGS) - 1));
            if (bus.out_ready) begin
                if (nxt == wr_idx) check("wr_data", 64'(bus.out_data), 64'(wr_val));
                cs = cs ^ regs[nxt];
                nxt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("beats", 64'(nxt), 64'(NUM_REGS));
        if (exp_cycles > 0) check("cycles", 64'(cyc), 64'(exp_cycles));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy",  64'(busy), 64'd1);
        check("done_valid", 64'(bus.out_valid), 64'd0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(cs));
`endif
        @(posedge clk); #1;
        check("post_done", 64'(done), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_valid", 64'(bus.out_valid), 64'd0);
        check("post_rdaddr", 64'(rd_addr), 64'd0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("checksum_hold", 64'(checksum), 64'(cs));
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] = (i == 0) ? '0 : DATA_WIDTH'(32'h100 + i);
        end
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");

        run_dump(0, -1, -1, -1, -1, '0, int'(NUM_REGS));        // full dump, no stall
        run_dump(0, 10, -1, -1, -1, '0, int'(NUM_REGS) + 3);    // 3-cycle stall on beat 10
        run_dump(0, -1, 4, -1, -1, '0, int'(NUM_REGS));         // start while busy
        run_dump(0, -1, -1, -1, -1, '0, int'(NUM_REGS));        // start right after done
        run_dump(0, -1, -1, 7, -1, '0, 0);                      // reset mid-dump
        run_dump(0, -1, -1, -1, 20, DATA_WIDTH'(32'hDEAD), int'(NUM_REGS));

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;
            run_dump(35, int'($urandom_range(NUM_REGS - 1)), int'($urandom_range(NUM_REGS - 1)),
                     -1, -1, '0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
